// File: rtl/button_event_collector_if.sv
// button_event_collector_if: valid/ready event stream from the collector to the processor
interface button_event_collector_if #(
    parameter int IDXW = 2
);
    logic            event_valid;
    logic [IDXW-1:0] event_code;
    logic            event_ready;
    modport master (output event_valid, event_code, input event_ready);
    modport slave (input event_valid, event_code, output event_ready);
endinterface

// File: rtl/button_event_collector.sv
// button_event_collector: arms debounce units, captures press edges, queues button indices in a FIFO
module button_event_collector #(
    parameter int NUM_BUTTONS = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_BUTTONS-1:0]        debounce,
    output logic [NUM_BUTTONS-1:0]        acknowledge,
    button_event_collector_if.master      evt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    press_total
);
    localparam int IDXW = NUM_BUTTONS > 1 ? $clog2(NUM_BUTTONS) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    typedef enum logic [1:0] {ARMED, PENDING, BUSY} state_t;

    state_t                 state    [NUM_BUTTONS];
    state_t                 state_nx [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] debounce_q;
    logic [NUM_BUTTONS-1:0] rise;
    logic [IDXW-1:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [CW-1:0]          count_nx;
    logic [IDXW-1:0]        gnt_idx;
    logic                   gnt_any;
    logic                   push;
    logic                   pop;
    logic                   full;

    assign rise            = debounce & ~debounce_q;
    assign full            = fifo_count == CW'(FIFO_DEPTH);
    assign pop             = evt.event_valid & evt.event_ready;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push            = gnt_any & (~full | pop);
    assign count_nx        = fifo_count + CW'(push) - CW'(pop);
    assign evt.event_valid = fifo_count != '0;
    assign evt.event_code  = mem[rd_ptr];

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--)
            if (state[i] == PENDING) begin
                gnt_any = 1'b1;
                gnt_idx = IDXW'(i);
            end
    end

    always_comb begin
        state_nx = state;
        for (int i = 0; i < NUM_BUTTONS; i++)
            state_nx[i] = state[i] == ARMED   ? (rise[i] ? PENDING : ARMED) :
                          state[i] == PENDING ? ((push && gnt_idx == IDXW'(i)) ? BUSY : PENDING) :
                          (debounce[i] ? BUSY : ARMED);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            debounce_q  <= '0;
            acknowledge <= '1;
            fifo_count  <= '0;
            press_total <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) state[i] <= ARMED;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            debounce_q <= debounce;
            state      <= state_nx;
            fifo_count <= count_nx;
            for (int i = 0; i < NUM_BUTTONS; i++)
                acknowledge[i] <= (state[i] == ARMED) && (count_nx < CW'(FIFO_DEPTH));
            if (push) begin
                mem[wr_ptr] <= gnt_idx;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && press_total != 8'hFF) press_total <= press_total + 8'd1;
        end
    end
endmodule
